// File: rtl/alu_issue.sv
// alu_issue: decodes RV32I R-type / I-type ALU instructions, reads operands from
// the local register file and presents a registered op bundle to the ALU with
// valid/ready handshaking. The writeback stage owns the register-file write port.
module alu_issue #(
    parameter int unsigned WORD_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          instr,
    input  logic                 wb_en,
    input  logic [4:0]           wb_addr,
    input  logic [WORD_SIZE-1:0] wb_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2:0]           alu_op,
    output logic [WORD_SIZE-1:0] arg1,
    output logic [WORD_SIZE-1:0] arg2,
    output logic [4:0]           rd,
    output logic                 illegal
);

    localparam int unsigned REG_COUNT = 32;
    localparam int unsigned ADDR_W    = 5;
    localparam int unsigned OP_W      = 3;
    localparam int unsigned IMM_W     = 12;

    localparam logic [6:0] OPC_R = 7'b0110011;
    localparam logic [6:0] OPC_I = 7'b0010011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [OP_W-1:0] OP_AND = 3'd0;
    localparam logic [OP_W-1:0] OP_OR  = 3'd1;
    localparam logic [OP_W-1:0] OP_XOR = 3'd2;
    localparam logic [OP_W-1:0] OP_SLL = 3'd3;
    localparam logic [OP_W-1:0] OP_SRL = 3'd4;
    localparam logic [OP_W-1:0] OP_ADD = 3'd5;
    localparam logic [OP_W-1:0] OP_SUB = 3'd6;

    logic [WORD_SIZE-1:0] rf [REG_COUNT];

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [ADDR_W-1:0] rs1_idx;
    logic [ADDR_W-1:0] rs2_idx;
    logic [ADDR_W-1:0] rd_idx;

    logic [OP_W-1:0]      dec_op;
    logic                 dec_illegal;
    logic                 dec_use_imm;
    logic [WORD_SIZE-1:0] dec_imm;
    logic [WORD_SIZE-1:0] imm_sext;
    logic [WORD_SIZE-1:0] imm_shamt;

    logic [WORD_SIZE-1:0] rs1_val;
    logic [WORD_SIZE-1:0] rs2_val;
    logic [WORD_SIZE-1:0] nxt_arg1;
    logic [WORD_SIZE-1:0] nxt_arg2;
    logic [ADDR_W-1:0]    nxt_rd;
    logic                 accept;

    assign opcode  = instr[6:0];
    assign rd_idx  = instr[11:7];
    assign funct3  = instr[14:12];
    assign rs1_idx = instr[19:15];
    assign rs2_idx = instr[24:20];
    assign funct7  = instr[31:25];

    assign imm_sext  = {{(WORD_SIZE-IMM_W){instr[31]}}, instr[31:20]};
    assign imm_shamt = WORD_SIZE'(instr[24:20]);

    // Stage can take a new instruction when the output slot is empty or draining.
    assign in_ready = !rst && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // Instruction decode: ALU op, immediate selection and legality.
    always_comb begin
        dec_op      = OP_ADD;
        dec_illegal = 1'b0;
        dec_use_imm = 1'b0;
        dec_imm     = '0;
        unique case (opcode)
            OPC_R: begin
                if (funct7 == F7_BASE) begin
                    unique case (funct3)
                        3'b000:  dec_op = OP_ADD;
                        3'b111:  dec_op = OP_AND;
                        3'b110:  dec_op = OP_OR;
                        3'b100:  dec_op = OP_XOR;
                        3'b001:  dec_op = OP_SLL;
                        3'b101:  dec_op = OP_SRL;
                        default: dec_illegal = 1'b1;
                    endcase
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    dec_op = OP_SUB;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            OPC_I: begin
                dec_use_imm = 1'b1;
                unique case (funct3)
                    3'b000: begin dec_op = OP_ADD; dec_imm = imm_sext; end
                    3'b111: begin dec_op = OP_AND; dec_imm = imm_sext; end
                    3'b110: begin dec_op = OP_OR;  dec_imm = imm_sext; end
                    3'b100: begin dec_op = OP_XOR; dec_imm = imm_sext; end
                    3'b001: begin
                        dec_op  = OP_SLL;
                        dec_imm = imm_shamt;
                        if (funct7 != F7_BASE) dec_illegal = 1'b1;
                    end
                    3'b101: begin
                        dec_op  = OP_SRL;
                        dec_imm = imm_shamt;
                        if (funct7 != F7_BASE) dec_illegal = 1'b1;
                    end
                    default: dec_illegal = 1'b1;
                endcase
            end
            default: dec_illegal = 1'b1;
        endcase
        if (dec_illegal) begin
            dec_op = OP_ADD;
        end
    end

    // Operand read with x0 forced to zero and write-first bypass from writeback.
    always_comb begin
        rs1_val = rf[rs1_idx];
        rs2_val = rf[rs2_idx];
        if (wb_en && wb_addr == rs1_idx) rs1_val = wb_data;
        if (wb_en && wb_addr == rs2_idx) rs2_val = wb_data;
        if (rs1_idx == '0) rs1_val = '0;
        if (rs2_idx == '0) rs2_val = '0;
    end

    // Bundle payload; illegal encodings are flattened to a harmless add 0,0 -> x0.
    always_comb begin
        nxt_arg1 = rs1_val;
        nxt_arg2 = dec_use_imm ? dec_imm : rs2_val;
        nxt_rd   = rd_idx;
        if (dec_illegal) begin
            nxt_arg1 = '0;
            nxt_arg2 = '0;
            nxt_rd   = '0;
        end
    end

    // Register file write port; x0 is never written, contents survive reset.
    always_ff @(posedge clk) begin
        if (wb_en && wb_addr != '0) begin
            rf[wb_addr] <= wb_data;
        end
    end

    // Output bundle register: load on accept, drop valid when drained, hold on stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            alu_op    <= '0;
            arg1      <= '0;
            arg2      <= '0;
            rd        <= '0;
            illegal   <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            alu_op    <= dec_op;
            arg1      <= nxt_arg1;
            arg2      <= nxt_arg2;
            rd        <= nxt_rd;
            illegal   <= dec_illegal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: expected bundles are queued at accept time
// and compared when the DUT hands a bundle to the ALU side.
module tb_alu_issue;

    localparam int unsigned W = 32;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a1;
        logic [W-1:0] a2;
        logic [4:0]   rd;
        logic         ill;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  instr;
    logic         wb_en;
    logic [4:0]   wb_addr;
    logic [W-1:0] wb_data;
    logic         out_valid;
    logic         out_ready;
    logic [2:0]   alu_op;
    logic [W-1:0] arg1;
    logic [W-1:0] arg2;
    logic [4:0]   rd;
    logic         illegal;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_push   = 0;
    int   n_pop    = 0;

    alu_issue #(.WORD_SIZE(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .alu_op(alu_op),
        .arg1(arg1), .arg2(arg2), .rd(rd), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [2:0] op, input logic [W-1:0] a1,
                                input logic [W-1:0] a2, input logic [4:0] r,
                                input logic ill);
        exp_t e;
        e.op = op; e.a1 = a1; e.a2 = a2; e.rd = r; e.ill = ill;
        return e;
    endfunction

    // Scoreboard: compare every bundle that completes its handshake.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_bundle", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                n_pop++;
                chk("alu_op",  32'(alu_op),  32'(e.op));
                chk("arg1",    arg1,         e.a1);
                chk("arg2",    arg2,         e.a2);
                chk("rd",      32'(rd),      32'(e.rd));
                chk("illegal", 32'(illegal), 32'(e.ill));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic issue(input logic [31:0] ins, input exp_t e);
        int n;
        n = 0;
        in_valid = 1'b1;
        instr    = ins;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 50) begin
                chk("accept_timeout", 32'd0, 32'd1);
                in_valid = 1'b0;
                return;
            end
        end
        q.push_back(e);
        n_push++;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [W-1:0] d);
        wb_en = 1'b1; wb_addr = a; wb_data = d;
        @(posedge clk); #1;
        wb_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; instr = '0; wb_en = 1'b0;
        wb_addr = '0; wb_data = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_alu_op",    32'(alu_op),    32'd0);
        chk("rst_arg1",      arg1,           32'd0);
        chk("rst_arg2",      arg2,           32'd0);
        chk("rst_rd",        32'(rd),        32'd0);
        chk("rst_illegal",   32'(illegal),   32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic R-type and I-type issue
        wb_write(5'd1, 32'h0000_0005);
        wb_write(5'd2, 32'h0000_0003);
        issue(32'h002081B3, mk(3'd5, 32'd5, 32'd3, 5'd3, 1'b0));
        chk("latency_valid", 32'(out_valid), 32'd1);
        issue(32'hFFF08213, mk(3'd5, 32'd5, 32'hFFFF_FFFF, 5'd4, 1'b0));
        issue(32'h0040D293, mk(3'd4, 32'd5, 32'd4, 5'd5, 1'b0));
        @(posedge clk); #1;
        chk("drain_valid", 32'(out_valid), 32'd0);

        // Back-pressure: bundle held stable while a second instruction waits
        out_ready = 1'b0;
        issue(32'h0020F433, mk(3'd0, 32'd5, 32'd3, 5'd8, 1'b0));
        in_valid = 1'b1;
        instr    = 32'h0020E4B3;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'h0000_0077;
            end
            @(negedge clk);
            chk("hold_valid",    32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready),  32'd0);
            chk("hold_alu_op",   32'(alu_op),    32'd0);
            chk("hold_arg1",     arg1,           32'd5);
            chk("hold_arg2",     arg2,           32'd3);
            chk("hold_rd",       32'(rd),        32'd8);
            @(posedge clk); #1;
            wb_en = 1'b0;
        end
        out_ready = 1'b1;
        issue(32'h0020E4B3, mk(3'd1, 32'h77, 32'd3, 5'd9, 1'b0));
        chk("consecutive_valid", 32'(out_valid), 32'd1);

        // Write-first bypass and x0 behaviour
        wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'hDEAD_BEEF;
        issue(32'h0000C333, mk(3'd2, 32'hDEAD_BEEF, 32'd0, 5'd6, 1'b0));
        wb_en = 1'b0;
        wb_write(5'd0, 32'h0000_1234);
        issue(32'h00000533, mk(3'd5, 32'd0, 32'd0, 5'd10, 1'b0));
        issue(32'h00008593, mk(3'd5, 32'hDEAD_BEEF, 32'd0, 5'd11, 1'b0));

        // sub, illegal encodings, immediate edge cases
        issue(32'h402083B3, mk(3'd6, 32'hDEAD_BEEF, 32'd3, 5'd7, 1'b0));
        issue(32'h4020D3B3, mk(3'd5, 32'd0, 32'd0, 5'd0, 1'b1));
        issue(32'h4040D293, mk(3'd5, 32'd0, 32'd0, 5'd0, 1'b1));
        issue(32'h00012083, mk(3'd5, 32'd0, 32'd0, 5'd0, 1'b1));
        issue(32'hFF017613, mk(3'd0, 32'd3, 32'hFFFF_FFF0, 5'd12, 1'b0));
        issue(32'h01F11693, mk(3'd3, 32'd3, 32'd31, 5'd13, 1'b0));
        @(posedge clk); #1;

        // Reset during a stall drops the bundle but keeps the register file
        out_ready = 1'b0;
        issue(32'h002081B3, mk(3'd5, 32'hDEAD_BEEF, 32'd3, 5'd3, 1'b0));
        @(negedge clk);
        chk("prerst_valid", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        wb_en = 1'b1; wb_addr = 5'd2; wb_data = 32'h0000_0099;
        @(negedge clk);
        chk("rst_mid_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        wb_en = 1'b0;
        q.delete();
        n_push--;
        @(negedge clk);
        chk("postrst_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        issue(32'h00208733, mk(3'd5, 32'hDEAD_BEEF, 32'h99, 5'd14, 1'b0));

        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", 32'(q.size()), 32'd0);
        chk("bundle_count", 32'(n_pop), 32'(n_push));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
